// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter that owns a 2:1 data mux and registers the muxed beat.
// A hold limit bounds one requester's tenure while the other is waiting.
module mux_rr_arbiter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic              last_q, last_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              sel_q, sel_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              xfer_c;
  logic [HW-1:0]     hold_inc_c;

  // Next-state, hold counter and datapath
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    last_d      = last_q;
    xfer_c      = (gnt0_q & req0) | (gnt1_q & req1);
    hold_inc_c  = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + HW'(1);
    out_valid_d = xfer_c;
    out_d       = xfer_c ? (sel_q ? I1 : I0) : out_q;

    case (state_q)
      IDLE: begin
        hold_cnt_d = '0;
        if (req0 && req1) state_d = last_q ? G0 : G1;
        else if (req0)    state_d = G0;
        else if (req1)    state_d = G1;
      end
      G0: begin
        if (!req0) begin
          // Owner released: hand over without a bubble, or go idle
          state_d    = req1 ? G1 : IDLE;
          hold_cnt_d = '0;
          last_d     = 1'b0;
        end else if (req1 && (hold_cnt_q == HOLD_LAST)) begin
          state_d    = G1;
          hold_cnt_d = '0;
          last_d     = 1'b0;
        end else begin
          hold_cnt_d = hold_inc_c;
        end
      end
      G1: begin
        if (!req1) begin
          state_d    = req0 ? G0 : IDLE;
          hold_cnt_d = '0;
          last_d     = 1'b1;
        end else if (req0 && (hold_cnt_q == HOLD_LAST)) begin
          state_d    = G0;
          hold_cnt_d = '0;
          last_d     = 1'b1;
        end else begin
          hold_cnt_d = hold_inc_c;
        end
      end
      default: begin
        state_d    = IDLE;
        hold_cnt_d = '0;
      end
    endcase

    gnt0_d = (state_d == G0);
    gnt1_d = (state_d == G1);
    sel_d  = (state_d == G1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_cnt_q  <= '0;
      last_q      <= 1'b1;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      sel_q       <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      last_q      <= last_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      sel_q       <= sel_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign sel       = sel_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Two-requester round-robin arbiter that shares the 2:1 data mux (inputs I0/I1, select sel, output out) between two sources.
- Owns the mux select, issues grants and registers the muxed beat.
- A hold limit bounds how long one requester keeps the mux while the other waits.
- Sits between two streaming sources and a single downstream consumer that has no backpressure.

Parameters:
- WIDTH, 8, data width of I0, I1, out.
- MAX_HOLD, 4, maximum consecutive granted beats per requester when the other is requesting. Must be >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- req0  input  1  requester 0 has a valid beat on I0
- req1  input  1  requester 1 has a valid beat on I1
- I0  input  WIDTH  requester 0 data
- I1  input  WIDTH  requester 1 data
- gnt0  output  1  requester 0 owns the mux (registered)
- gnt1  output  1  requester 1 owns the mux (registered)
- sel  output  1  mux select: 0 selects I0, 1 selects I1 (registered)
- out  output  WIDTH  registered muxed data
- out_valid  output  1  out holds a transferred beat this cycle

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE; gnt0=gnt1=0; sel=0; out=0; out_valid=0; hold_cnt=0; last=1.
  - The first contended grant therefore goes to requester 0.
  - Reset has priority over all other events; an in-flight beat is dropped.
- States:
  - IDLE, G0, G1.
  - gnt0=(state==G0), gnt1=(state==G1), sel=(state==G1); all registered.
  - gnt0 and gnt1 are never both 1.
- Transfer rule:
  - A beat transfers on any cycle where (gnt0 & req0) or (gnt1 & req1).
  - Next cycle: out=data of the granted input, sampled at that edge; out_valid=1.
  - Otherwise out_valid=0 and out holds its last value.
  - Latency: req seen at IDLE edge t -> grant at t+1 -> first out_valid at t+2. Thereafter 1 beat/cycle.
- IDLE transitions:
  - req0 & req1: go to G0 if last==1, else G1.
  - Only req0: go to G0. Only req1: go to G1. Neither: stay in IDLE.
  - hold_cnt=0.
- Gx transitions (x = current owner, y = other requester):
  - !reqx & reqy: go to Gy; hold_cnt=0; last=x. No idle bubble.
  - !reqx & !reqy: go to IDLE; last=x.
  - reqx & reqy & hold_cnt==MAX_HOLD-1: forced switch to Gy; hold_cnt=0; last=x. The beat on this cycle still transfers.
  - Otherwise stay in Gx; hold_cnt increments, saturating at MAX_HOLD-1.
- hold_cnt:
  - Width clog2(MAX_HOLD), minimum 1 bit.
  - Counts beats transferred in the current tenure.
  - With MAX_HOLD=1, grants alternate every beat under contention.
- Uncontended owner: keeps the grant indefinitely; the saturated hold_cnt causes no switch.
- Simultaneous requester drop and forced-switch condition: the drop rule applies (switch to Gy if reqy, else IDLE).
- Data not granted on a cycle is ignored. Requesters must hold data stable only on cycles where their req is high.

Test Plan:
- Reset hold: rst=1 for 2 cycles with req0=req1=1, I0=8'h11, I1=8'h22 -> gnt0=gnt1=0, sel=0, out=0, out_valid=0 throughout.
- Single requester: after reset, req0=1, I0=8'hA5 from cycle 0 -> gnt0=1 at cycle 1; out=A5, out_valid=1 from cycle 2; gnt0 stays high for 20+ cycles; sel=0 throughout.
- Contention (MAX_HOLD=4): req0=req1=1 continuously, I0=8'h0A, I1=8'hB0 ->
  - gnt0 for 4 cycles, then gnt1 for 4 cycles, repeating.
  - out shows four 0A then four B0, lagging the grant by 1 cycle.
  - out_valid stays 1 with no gap.
- Early release: in G0 after 2 beats, drop req0 while req1=1 -> gnt1=1 and sel=1 the next cycle. gnt1 then holds for a full 4 beats under renewed contention, confirming hold_cnt restarted.
- Fairness: req1 alone for 3 beats, then req1 drops and req0 and req1 rise together from IDLE -> G0 wins (last=1). Repeat ending on G0 -> G1 wins.
- Reset mid-burst: rst=1 for one cycle while in G1 with hold_cnt=2 -> next cycle IDLE, gnt1=0, sel=0, out_valid=0. After release with req0=req1=1 -> gnt0 is granted first.
